key_input_controller: RTL and testbench

- Parametrised successor to the 4-key/3-switch front end. It takes NUM_KEYS push-buttons and NUM_SW slide switches, then synchronises, debounces and polarity-normalises every input.
- The shift switch routes each press to a KEY or CMD bank.
- Adds per-key auto-repeat (typematic) and long-press detection.
- Sits between the board pins and the terminal's command/entry logic, and replaces the fixed-width controller.

---
 rtl/key_input_controller.sv | 171 +++++++++++++++++
 tb/tb_key_input_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_input_controller.sv
// Key/switch front end: 2-flop sync, debounce, polarity normalisation, bank routing,
// per-key typematic repeat and long-press detection.
module key_input_controller #(
   parameter int unsigned NUM_KEYS         = 4,
   parameter int unsigned NUM_SW           = 3,
   parameter int unsigned SHIFT_SW         = 0,
   parameter int unsigned DBNC_CNT_W       = 16,
   parameter int unsigned KEY_ACTIVE_LOW   = 1,
   parameter int unsigned REPEAT_DELAY_CYC = 25000000,
   parameter int unsigned REPEAT_RATE_CYC  = 5000000,
   parameter int unsigned LONG_PRESS_CYC   = 50000000
) (
   input  logic                CLOCK_50,
   input  logic                RESET,
   input  logic [NUM_KEYS-1:0] KEY,
   input  logic [NUM_SW-1:0]   SW,
   input  logic                REPEAT_EN,
   output logic [NUM_SW-1:0]   CleanSWOut,
   output logic [NUM_KEYS-1:0] KEY_Reg,
   output logic [NUM_KEYS-1:0] CMD_Reg,
   output logic [NUM_KEYS-1:0] KEY_En,
   output logic [NUM_KEYS-1:0] CMD_En,
   output logic [NUM_KEYS-1:0] LongPress
);

   localparam int unsigned NUM_IN  = NUM_KEYS + NUM_SW;
   localparam logic        KAL     = (KEY_ACTIVE_LOW != 0);
   localparam int unsigned MAX_A   = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
   localparam int unsigned MAX_CYC = (MAX_A > LONG_PRESS_CYC) ? MAX_A : LONG_PRESS_CYC;
   localparam int unsigned TMR_W   = $clog2(MAX_CYC);
   localparam int unsigned HOLD_W  = $clog2(LONG_PRESS_CYC + 1);

   localparam logic [NUM_IN-1:0] REL_LVL  = {{NUM_SW{1'b0}}, {NUM_KEYS{KAL}}};
   localparam logic [TMR_W-1:0]  DLY_LD   = TMR_W'(REPEAT_DELAY_CYC - 1);
   localparam logic [TMR_W-1:0]  RATE_LD  = TMR_W'(REPEAT_RATE_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYC);
   localparam logic [HOLD_W-1:0] LP_FIRE  = HOLD_W'(LONG_PRESS_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_REPEAT,
      ST_HOLD
   } key_state_e;

   logic [NUM_IN-1:0]     sync1_q, sync2_q, stable_q, stable_d;
   logic [DBNC_CNT_W-1:0] dbc_q [NUM_IN];
   logic [DBNC_CNT_W-1:0] dbc_d [NUM_IN];
   logic [NUM_KEYS-1:0]   pressed;

   key_state_e          state_q [NUM_KEYS];
   key_state_e          state_d [NUM_KEYS];
   logic [TMR_W-1:0]    timer_q [NUM_KEYS];
   logic [TMR_W-1:0]    timer_d [NUM_KEYS];
   logic [HOLD_W-1:0]   hold_q  [NUM_KEYS];
   logic [HOLD_W-1:0]   hold_d  [NUM_KEYS];
   logic [NUM_KEYS-1:0] bank_q, bank_d;
   logic [NUM_KEYS-1:0] pulse;
   logic [NUM_KEYS-1:0] key_en_q, key_en_d, cmd_en_q, cmd_en_d;

   always_comb begin
      stable_d = stable_q;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         dbc_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (dbc_q[i] == '1) stable_d[i] = sync2_q[i];
            else                dbc_d[i]    = dbc_q[i] + 1'b1;
         end
      end
   end

   assign pressed    = stable_q[NUM_KEYS-1:0] ^ {NUM_KEYS{KAL}};
   assign CleanSWOut = stable_q[NUM_IN-1:NUM_KEYS];

   always_comb begin
      bank_d = bank_q;
      pulse  = '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         state_d[i] = state_q[i];
         timer_d[i] = timer_q[i];
         hold_d[i]  = hold_q[i];
         if (!pressed[i]) begin
            state_d[i] = ST_IDLE;
            timer_d[i] = '0;
            hold_d[i]  = '0;
         end else begin
            // Hold count runs in every held state, independent of the repeat path.
            if (state_q[i] != ST_IDLE && hold_q[i] != HOLD_MAX) hold_d[i] = hold_q[i] + 1'b1;
            case (state_q[i])
               ST_IDLE: begin
                  pulse[i]   = 1'b1;
                  timer_d[i] = DLY_LD;
                  hold_d[i]  = '0;
                  bank_d[i]  = stable_q[NUM_KEYS + SHIFT_SW];
                  state_d[i] = ST_DELAY;
               end
               ST_DELAY: begin
                  if (timer_q[i] == '0) begin
                     if (REPEAT_EN) begin
                        pulse[i]   = 1'b1;
                        timer_d[i] = RATE_LD;
                        state_d[i] = ST_REPEAT;
                     end else begin
                        state_d[i] = ST_HOLD;
                     end
                  end else begin
                     timer_d[i] = timer_q[i] - 1'b1;
                  end
               end
               ST_REPEAT: begin
                  if (!REPEAT_EN) begin
                     state_d[i] = ST_HOLD;
                     timer_d[i] = '0;
                  end else if (timer_q[i] == '0) begin
                     pulse[i]   = 1'b1;
                     timer_d[i] = RATE_LD;
                  end else begin
                     timer_d[i] = timer_q[i] - 1'b1;
                  end
               end
               ST_HOLD: ;
               default: state_d[i] = ST_IDLE;
            endcase
         end
      end
      key_en_d = pulse & ~bank_d;
      cmd_en_d = pulse & bank_d;
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         sync1_q  <= REL_LVL;
         sync2_q  <= REL_LVL;
         stable_q <= REL_LVL;
         bank_q   <= '0;
         key_en_q <= '0;
         cmd_en_q <= '0;
         for (int unsigned i = 0; i < NUM_IN; i++) dbc_q[i] <= '0;
         for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            state_q[i] <= ST_IDLE;
            timer_q[i] <= '0;
            hold_q[i]  <= '0;
         end
      end else begin
         sync1_q  <= {SW, KEY};
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         bank_q   <= bank_d;
         key_en_q <= key_en_d;
         cmd_en_q <= cmd_en_d;
         for (int unsigned i = 0; i < NUM_IN; i++) dbc_q[i] <= dbc_d[i];
         for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            state_q[i] <= state_d[i];
            timer_q[i] <= timer_d[i];
            hold_q[i]  <= hold_d[i];
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         KEY_Reg[i]   = (state_q[i] != ST_IDLE) & ~bank_q[i];
         CMD_Reg[i]   = (state_q[i] != ST_IDLE) &  bank_q[i];
         LongPress[i] = (hold_q[i] == LP_FIRE);
      end
   end

   assign KEY_En = key_en_q;
   assign CMD_En = cmd_en_q;

endmodule

// File: tb/tb_key_input_controller.sv
// Self-checking bench for key_input_controller: directed plan scenarios plus
// randomized traffic, compared every cycle against an offset-based reference model.
module tb_key_input_controller;

   localparam int unsigned NK = 4;
   localparam int unsigned NS = 3;
   localparam int unsigned DW = 2;
   localparam int unsigned RD = 20;
   localparam int unsigned RR = 8;
   localparam int unsigned LP = 30;
   localparam int unsigned DB = 1 << DW;

   logic          clk = 1'b0;
   logic          rst;
   logic [NK-1:0] key;
   logic [NS-1:0] sw;
   logic          rep_en;
   logic [NS-1:0] clean_sw;
   logic [NK-1:0] key_reg, cmd_reg, key_en, cmd_en, long_press;

   key_input_controller #(
      .NUM_KEYS(NK), .NUM_SW(NS), .SHIFT_SW(0), .DBNC_CNT_W(DW), .KEY_ACTIVE_LOW(1),
      .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR), .LONG_PRESS_CYC(LP)
   ) dut (
      .CLOCK_50(clk), .RESET(rst), .KEY(key), .SW(sw), .REPEAT_EN(rep_en),
      .CleanSWOut(clean_sw), .KEY_Reg(key_reg), .CMD_Reg(cmd_reg),
      .KEY_En(key_en), .CMD_En(cmd_en), .LongPress(long_press)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned cyc   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, act, exp);
      end
   endtask

   // Reference model: raw inputs reach the debouncer two edges late; a level is
   // accepted after DB consecutive differing samples; key behaviour is a function
   // of the offset since the first pulse.
   logic [NK-1:0] mk_p1, mk_p2, mk_stab;
   logic [NS-1:0] ms_p1, ms_p2, ms_stab;
   int unsigned   mk_run [NK];
   int unsigned   ms_run [NS];
   bit            m_act  [NK];
   bit            m_dead [NK];
   bit            m_bank [NK];
   bit            m_en   [NK];
   bit            m_lp   [NK];
   int unsigned   m_ofs  [NK];

   task automatic model_edge();
      if (rst) begin
         mk_p1 = '1; mk_p2 = '1; mk_stab = '1;
         ms_p1 = '0; ms_p2 = '0; ms_stab = '0;
         for (int i = 0; i < NK; i++) begin
            mk_run[i] = 0; m_act[i] = 0; m_en[i] = 0; m_lp[i] = 0; m_bank[i] = 0;
         end
         for (int i = 0; i < NS; i++) ms_run[i] = 0;
      end else begin
         for (int i = 0; i < NK; i++) begin
            m_en[i] = 0;
            m_lp[i] = 0;
            if (mk_stab[i]) begin
               m_act[i] = 0;
            end else if (!m_act[i]) begin
               m_act[i] = 1; m_ofs[i] = 0; m_dead[i] = 0;
               m_bank[i] = ms_stab[0];
               m_en[i] = 1;
            end else begin
               m_ofs[i]++;
               if (m_ofs[i] >= RD && !rep_en) m_dead[i] = 1;
               m_en[i] = (m_ofs[i] >= RD) && !m_dead[i] && ((m_ofs[i] - RD) % RR == 0);
               m_lp[i] = (m_ofs[i] == LP - 1);
            end
         end
         for (int i = 0; i < NK; i++) begin
            if (mk_p2[i] != mk_stab[i]) begin
               mk_run[i]++;
               if (mk_run[i] == DB) begin mk_stab[i] = mk_p2[i]; mk_run[i] = 0; end
            end else mk_run[i] = 0;
         end
         for (int i = 0; i < NS; i++) begin
            if (ms_p2[i] != ms_stab[i]) begin
               ms_run[i]++;
               if (ms_run[i] == DB) begin ms_stab[i] = ms_p2[i]; ms_run[i] = 0; end
            end else ms_run[i] = 0;
         end
         mk_p2 = mk_p1; mk_p1 = key;
         ms_p2 = ms_p1; ms_p1 = sw;
      end
   endtask

   task automatic compare();
      logic [NK-1:0] e_ken, e_cen, e_kr, e_cr, e_lp;
      for (int i = 0; i < NK; i++) begin
         e_ken[i] = m_en[i] & ~m_bank[i];
         e_cen[i] = m_en[i] &  m_bank[i];
         e_kr[i]  = m_act[i] & ~m_bank[i];
         e_cr[i]  = m_act[i] &  m_bank[i];
         e_lp[i]  = m_lp[i];
      end
      chk("KEY_En",     32'(key_en),     32'(e_ken));
      chk("CMD_En",     32'(cmd_en),     32'(e_cen));
      chk("KEY_Reg",    32'(key_reg),    32'(e_kr));
      chk("CMD_Reg",    32'(cmd_reg),    32'(e_cr));
      chk("LongPress",  32'(long_press), 32'(e_lp));
      chk("CleanSWOut", 32'(clean_sw),   32'(ms_stab));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      compare();
   endtask

   task automatic steps(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) step();
   endtask

   task automatic wait_pulse(input int unsigned k, output int unsigned lat);
      int unsigned c0;
      c0  = cyc;
      lat = 999;
      for (int n = 0; n < 30; n++) begin
         step();
         if (key_en[k] | cmd_en[k]) begin
            lat = cyc - c0;
            return;
         end
      end
   endtask

   int unsigned lat, np, nlp;

   initial begin
      rst = 1'b1; key = '1; sw = '0; rep_en = 1'b0;
      steps(2);
      rst = 1'b0;
      steps(10);

      // Latency of first pulse after a press
      key[1] = 1'b0;
      wait_pulse(1, lat);
      chk("latency_key1", lat, 7);
      steps(30);
      key[1] = 1'b1;
      steps(15);

      // 3-cycle glitch is filtered, 4-cycle low is accepted
      np = 0;
      key[0] = 1'b0; steps(3); key[0] = 1'b1;
      for (int n = 0; n < 20; n++) begin step(); if (key_en[0]) np++; end
      chk("glitch3_pulses", np, 0);
      np = 0;
      key[0] = 1'b0; step(); if (key_en[0]) np++;
      step(); step(); step(); key[0] = 1'b1;
      for (int n = 0; n < 20; n++) begin step(); if (key_en[0]) np++; end
      chk("glitch4_pulses", np, 1);

      // Repeat plus long press on KEY[2]
      rep_en = 1'b1;
      key[2] = 1'b0;
      wait_pulse(2, lat);
      np = 1; nlp = 0;
      for (int n = 1; n <= 50; n++) begin
         step();
         if (key_en[2]) np++;
         if (long_press[2]) nlp++;
      end
      key[2] = 1'b1;
      for (int n = 0; n < 30; n++) begin
         step();
         if (key_en[2]) np++;
         if (long_press[2]) nlp++;
      end
      chk("repeat_pulses_key2", np, 6);
      chk("longpress_key2", nlp, 1);

      // Bank latch: press in CMD bank, flip shift mid-hold
      sw[0] = 1'b1;
      steps(10);
      key[3] = 1'b0;
      wait_pulse(3, lat);
      chk("cmd_bank_pulse", 32'(cmd_en[3]), 1);
      steps(10);
      sw[0] = 1'b0;
      steps(40);
      key[3] = 1'b1;
      steps(15);

      // REPEAT_EN dropped during repeat on KEY[0]
      rep_en = 1'b1;
      key[0] = 1'b0;
      wait_pulse(0, lat);
      steps(24);
      rep_en = 1'b0;
      steps(20);
      key[0] = 1'b1;
      steps(15);

      // Reset mid-hold, key still pressed
      key[1] = 1'b0;
      wait_pulse(1, lat);
      steps(10);
      rst = 1'b1;
      step();
      rst = 1'b0;
      wait_pulse(1, lat);
      chk("latency_after_reset", lat, 7);
      steps(20);
      key[1] = 1'b1;
      steps(15);

      // Randomized traffic at several toggle rates
      for (int ph = 0; ph < 3; ph++) begin
         int unsigned rate;
         rate = (ph == 0) ? 3 : (ph == 1) ? 30 : 120;
         for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NK; i++)
               if ($urandom_range(0, rate - 1) == 0) key[i] = ~key[i];
            if ($urandom_range(0, 89) == 0) begin
               int unsigned s;
               s = $urandom_range(0, NS - 1);
               sw[s] = ~sw[s];
            end
            if ($urandom_range(0, 59) == 0) rep_en = ~rep_en;
            rst = ($urandom_range(0, 799) == 0);
            step();
         end
      end
      rst = 1'b0;
      steps(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
